// File: rtl/bus_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_datapath_pkg
// Brief   : Shared constants and types for the bus datapath: bus source /
//           register indices, ALU opcodes and the memory FSM state type.
// Rev     : 1.0  initial release
// ============================================================================
package bus_datapath_pkg;

    localparam int c_num_src   = 14;

    localparam int c_idx_ac    = 0;
    localparam int c_idx_l     = 1;
    localparam int c_idx_x     = 2;
    localparam int c_idx_cp    = 3;
    localparam int c_idx_j     = 4;
    localparam int c_idx_t     = 5;
    localparam int c_idx_h     = 6;
    localparam int c_idx_w     = 7;
    localparam int c_idx_k     = 8;
    localparam int c_idx_count = 9;
    localparam int c_idx_mar   = 10;
    localparam int c_idx_mdr   = 11;
    localparam int c_idx_pc    = 12;
    localparam int c_idx_ir    = 13;

    localparam logic [2:0] c_alu_pass = 3'd0;
    localparam logic [2:0] c_alu_add  = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_inc  = 3'd3;
    localparam logic [2:0] c_alu_dec  = 3'd4;
    localparam logic [2:0] c_alu_and  = 3'd5;
    localparam logic [2:0] c_alu_or   = 3'd6;
    localparam logic [2:0] c_alu_shl  = 3'd7;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_datapath_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_datapath_if
// Brief   : Data-memory request/acknowledge bus between datapath and DRAM.
// Rev     : 1.0  initial release
// ============================================================================
interface bus_datapath_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          dram_req;
    logic          dram_we;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic [DW-1:0] dram_rdata;
    logic          dram_ack;

    modport master (
        output dram_req, dram_we, dram_addr, dram_wdata,
        input  dram_rdata, dram_ack
    );

    modport slave (
        input  dram_req, dram_we, dram_addr, dram_wdata,
        output dram_rdata, dram_ack
    );
endinterface
`default_nettype wire

// File: rtl/bus_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module  : dp_alu
// Brief   : Combinational accumulator ALU, all results modulo 2^DW.
// Rev     : 1.0  initial release
// ============================================================================
module dp_alu
    import bus_datapath_pkg::*;
#(
    parameter int DW = 16
) (
    input  wire logic [DW-1:0] i_ac,
    input  wire logic [DW-1:0] i_bus,
    input  wire logic [2:0]    i_alu_op,
    output logic      [DW-1:0] o_result
);

    always_comb begin
        o_result = i_bus;
        case (i_alu_op)
            c_alu_pass: o_result = i_bus;
            c_alu_add:  o_result = i_ac + i_bus;
            c_alu_sub:  o_result = i_ac - i_bus;
            c_alu_inc:  o_result = i_ac + DW'(1);
            c_alu_dec:  o_result = i_ac - DW'(1);
            c_alu_and:  o_result = i_ac & i_bus;
            c_alu_or:   o_result = i_ac | i_bus;
            c_alu_shl:  o_result = {i_ac[DW-2:0], 1'b0};
            default:    o_result = i_bus;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_datapath.sv
`default_nettype none
// ============================================================================
// Module  : bus_datapath
// Brief   : Single-bus register datapath with accumulator ALU, PC/IR and a
//           four-state data-memory transaction engine.
// Rev     : 1.0  initial release
// ============================================================================
module bus_datapath
    import bus_datapath_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [13:0]   bus_rd,
    input  wire logic [13:0]   reg_wr,
    input  wire logic [2:0]    alu_op,
    input  wire logic          alu_mux,
    input  wire logic          ac_reset,
    input  wire logic          pc_inc,
    input  wire logic          iram_read,
    input  wire logic          dram_read,
    input  wire logic          dram_write,
    output logic      [AW-1:0] iram_addr,
    input  wire logic [23:0]   iram_data,
    output logic      [23:0]   ir_out,
    output logic               neg_flag,
    output logic               mem_busy,
    output logic               mem_done,
    output logic               bus_err,
    bus_datapath_if.master     dram
);

    logic [DW-1:0] r_ac;
    logic [DW-1:0] r_gen [1:9];
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_mdr;
    logic [AW-1:0] r_pc;
    logic [23:0]   r_ir;
    logic          r_neg;
    logic          r_bus_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_op_write;
    mem_state_e    r_state;
    mem_state_e    w_state_next;

    logic [DW-1:0] w_src [0:13];
    logic [DW-1:0] w_bus;
    logic          w_bus_fault;
    logic [DW-1:0] w_mar_dw;
    logic [DW-1:0] w_pc_dw;
    logic [DW-1:0] w_ir_dw;
    logic [AW-1:0] w_bus_aw;
    logic [DW-1:0] w_alu_y;
    logic [DW-1:0] w_ac_next;
    logic          w_start;
    logic          w_req_out;
    logic          w_busy;
    logic          w_done;
    logic          w_rd_complete;
    logic          w_mem_err;
    logic          w_unused;

    assign w_unused = reg_wr[c_idx_ir];

    // Width adaption between the DW-wide bus and the AW-wide address registers
    generate
        if (AW == DW) begin : g_aw_eq
            assign w_mar_dw = r_mar;
            assign w_pc_dw  = r_pc;
            assign w_bus_aw = w_bus;
        end else if (AW > DW) begin : g_aw_wide
            assign w_mar_dw = r_mar[DW-1:0];
            assign w_pc_dw  = r_pc[DW-1:0];
            assign w_bus_aw = {{(AW-DW){1'b0}}, w_bus};
        end else begin : g_aw_narrow
            assign w_mar_dw = {{(DW-AW){1'b0}}, r_mar};
            assign w_pc_dw  = {{(DW-AW){1'b0}}, r_pc};
            assign w_bus_aw = w_bus[AW-1:0];
        end

        if (DW == 24) begin : g_ir_eq
            assign w_ir_dw = r_ir;
        end else if (DW < 24) begin : g_ir_slice
            assign w_ir_dw = r_ir[DW-1:0];
        end else begin : g_ir_ext
            assign w_ir_dw = {{(DW-24){1'b0}}, r_ir};
        end
    endgenerate

    always_comb begin
        w_src[c_idx_ac] = r_ac;
        for (int i = 1; i <= 9; i++) begin
            w_src[i] = r_gen[i];
        end
        w_src[c_idx_mar] = w_mar_dw;
        w_src[c_idx_mdr] = r_mdr;
        w_src[c_idx_pc]  = w_pc_dw;
        w_src[c_idx_ir]  = w_ir_dw;
    end

    // A non-one-hot select drives zero rather than an OR of sources
    always_comb begin
        w_bus_fault = !$onehot(bus_rd);
        w_bus       = '0;
        if (!w_bus_fault) begin
            for (int i = 0; i < c_num_src; i++) begin
                if (bus_rd[i]) w_bus = w_bus | w_src[i];
            end
        end
    end

    dp_alu #(.DW(DW)) u_alu (
        .i_ac     (r_ac),
        .i_bus    (w_bus),
        .i_alu_op (alu_op),
        .o_result (w_alu_y)
    );

    assign w_ac_next = alu_mux ? w_alu_y : w_bus;

    always_ff @(posedge clk) begin
        if (reset || ac_reset) begin
            r_ac  <= '0;
            r_neg <= 1'b0;
        end else if (reg_wr[c_idx_ac]) begin
            r_ac  <= w_ac_next;
            r_neg <= w_ac_next[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= 9; i++) r_gen[i] <= '0;
            r_mar <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
        end else begin
            for (int i = 1; i <= 9; i++) begin
                if (reg_wr[i]) r_gen[i] <= w_bus;
            end
            if (reg_wr[c_idx_mar]) r_mar <= w_bus_aw;
            if (reg_wr[c_idx_pc])  r_pc  <= w_bus_aw;
            else if (pc_inc)       r_pc  <= r_pc + AW'(1);
            if (iram_read)         r_ir  <= iram_data;
        end
    end

    // Memory read data takes precedence over a bus load in the same cycle
    always_ff @(posedge clk) begin
        if (reset)                  r_mdr <= '0;
        else if (w_rd_complete)     r_mdr <= dram.dram_rdata;
        else if (reg_wr[c_idx_mdr]) r_mdr <= w_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= MS_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_req_out     = 1'b0;
        w_busy        = 1'b1;
        w_done        = 1'b0;
        w_rd_complete = 1'b0;
        w_mem_err     = dram_read || dram_write;
        case (r_state)
            MS_IDLE: begin
                w_busy    = 1'b0;
                w_mem_err = dram_read && dram_write;
                if (dram_read || dram_write) begin
                    w_start      = 1'b1;
                    w_state_next = MS_REQ;
                end
            end
            MS_REQ: begin
                w_req_out    = 1'b1;
                w_state_next = MS_WAIT;
            end
            MS_WAIT: begin
                if (dram.dram_ack) begin
                    w_rd_complete = !r_op_write;
                    w_state_next  = MS_DONE;
                end
            end
            MS_DONE: begin
                w_done       = 1'b1;
                w_state_next = MS_IDLE;
            end
            default: w_state_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
        end else if (w_start) begin
            r_addr     <= r_mar;
            r_op_write <= dram_write;
            if (dram_write) r_wdata <= r_mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_bus_err <= 1'b0;
        else       r_bus_err <= r_bus_err | w_bus_fault | w_mem_err;
    end

    assign dram.dram_req   = w_req_out;
    assign dram.dram_we    = w_req_out && r_op_write;
    assign dram.dram_addr  = r_addr;
    assign dram.dram_wdata = r_wdata;

    assign iram_addr = r_pc;
    assign ir_out    = r_ir;
    assign neg_flag  = r_neg;
    assign mem_busy  = w_busy;
    assign mem_done  = w_done;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_datapath
// Brief   : Directed self-checking bench for bus_datapath.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_datapath;
    import bus_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] bus_rd;
    logic [13:0] reg_wr;
    logic [2:0]  alu_op;
    logic        alu_mux, ac_reset, pc_inc, iram_read, dram_read, dram_write;
    logic [15:0] iram_addr;
    logic [23:0] iram_data;
    logic [23:0] ir_out;
    logic        neg_flag, mem_busy, mem_done, bus_err;

    int checks = 0;
    int errors = 0;

    bus_datapath_if #(.DW(16), .AW(16)) dram_bus ();

    bus_datapath #(.DW(16), .AW(16)) dut (
        .clk(clk), .reset(reset), .bus_rd(bus_rd), .reg_wr(reg_wr),
        .alu_op(alu_op), .alu_mux(alu_mux), .ac_reset(ac_reset), .pc_inc(pc_inc),
        .iram_read(iram_read), .dram_read(dram_read), .dram_write(dram_write),
        .iram_addr(iram_addr), .iram_data(iram_data), .ir_out(ir_out),
        .neg_flag(neg_flag), .mem_busy(mem_busy), .mem_done(mem_done),
        .bus_err(bus_err), .dram(dram_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] sel(int idx);
        logic [13:0] one;
        one = 14'd1;
        return one << idx;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    // Loads a register with a constant by way of IR
    task automatic load_imm(int idx, logic [15:0] v);
        iram_data = {8'h00, v}; iram_read = 1'b1; cyc(); iram_read = 1'b0;
        bus_rd = sel(c_idx_ir); reg_wr = sel(idx); alu_mux = 1'b0; cyc();
        reg_wr = '0; bus_rd = sel(c_idx_ac);
    endtask

    // Observes a register by copying it into PC and reading iram_addr
    task automatic peek(int idx, output logic [15:0] v);
        bus_rd = sel(idx); reg_wr = sel(c_idx_pc); cyc();
        v = iram_addr;
        reg_wr = '0; bus_rd = sel(c_idx_ac);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1; reg_wr = '1; pc_inc = 1'b1; iram_read = 1'b1; iram_data = 24'hABCDEF;
        cyc(); cyc();
        reg_wr = '0; pc_inc = 1'b0; iram_read = 1'b0;
        cyc();
        reset = 1'b0;
        checks++; if (iram_addr !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", iram_addr); end
        checks++; if (ir_out !== 24'h0) begin errors++; $display("FAIL reset_ir got %h want 000000", ir_out); end
        checks++; if ({neg_flag, bus_err, mem_busy, mem_done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {neg_flag, bus_err, mem_busy, mem_done}); end
        checks++; if ({dram_bus.dram_req, dram_bus.dram_we, dram_bus.dram_addr, dram_bus.dram_wdata} !== 34'h0) begin errors++; $display("FAIL reset_dram got %b %b %h %h want 0 0 0000 0000", dram_bus.dram_req, dram_bus.dram_we, dram_bus.dram_addr, dram_bus.dram_wdata); end
        peek(c_idx_ac, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_ac got %h want 0000", v); end
    endtask

    task automatic test_bus_move();
        logic [15:0] v;
        load_imm(c_idx_x, 16'h1234);
        checks++; if (ir_out !== 24'h001234) begin errors++; $display("FAIL ir_load got %h want 001234", ir_out); end
        bus_rd = sel(c_idx_x); reg_wr = sel(c_idx_l); cyc(); reg_wr = '0; bus_rd = sel(c_idx_ac);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL move_bus_err got %b want 0", bus_err); end
        peek(c_idx_l, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL move_x_to_l got %h want 1234", v); end
        bus_rd = sel(c_idx_x); reg_wr = sel(c_idx_t) | sel(c_idx_h); cyc(); reg_wr = '0; bus_rd = sel(c_idx_ac);
        peek(c_idx_t, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL multi_load_t got %h want 1234", v); end
        peek(c_idx_h, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL multi_load_h got %h want 1234", v); end
    endtask

    task automatic test_alu();
        logic [15:0] v;
        logic [15:0] exp_v [8] = '{16'h0F0F, 16'h9330, 16'h7512, 16'h8422,
                                   16'h8420, 16'h0401, 16'h8F2F, 16'h0842};
        logic        exp_n [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        load_imm(c_idx_ac, 16'h0001);
        load_imm(c_idx_j, 16'h0002);
        bus_rd = sel(c_idx_j); alu_op = 3'd2; alu_mux = 1'b1; reg_wr = sel(c_idx_ac); cyc();
        reg_wr = '0; alu_mux = 1'b0; bus_rd = sel(c_idx_ac);
        checks++; if (neg_flag !== 1'b1) begin errors++; $display("FAIL sub_neg got %b want 1", neg_flag); end
        peek(c_idx_ac, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL sub_ac got %h want FFFF", v); end
        ac_reset = 1'b1; cyc(); ac_reset = 1'b0;
        checks++; if (neg_flag !== 1'b0) begin errors++; $display("FAIL acrst_neg got %b want 0", neg_flag); end
        peek(c_idx_ac, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL acrst_ac got %h want 0000", v); end

        load_imm(c_idx_j, 16'h0F0F);
        for (int op = 0; op < 8; op++) begin
            load_imm(c_idx_ac, 16'h8421);
            bus_rd = sel(c_idx_j); alu_op = 3'(op); alu_mux = 1'b1; reg_wr = sel(c_idx_ac); cyc();
            reg_wr = '0; alu_mux = 1'b0; bus_rd = sel(c_idx_ac);
            checks++; if (neg_flag !== exp_n[op]) begin errors++; $display("FAIL alu_op%0d_neg got %b want %b", op, neg_flag, exp_n[op]); end
            peek(c_idx_ac, v);
            checks++; if (v !== exp_v[op]) begin errors++; $display("FAIL alu_op%0d got %h want %h", op, v, exp_v[op]); end
        end

        load_imm(c_idx_ac, 16'h0005);
        ac_reset = 1'b1; bus_rd = sel(c_idx_j); reg_wr = sel(c_idx_ac); cyc();
        ac_reset = 1'b0; reg_wr = '0; bus_rd = sel(c_idx_ac);
        peek(c_idx_ac, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL acrst_priority got %h want 0000", v); end
    endtask

    task automatic test_pc();
        load_imm(c_idx_pc, 16'hFFFF);
        checks++; if (iram_addr !== 16'hFFFF) begin errors++; $display("FAIL pc_load got %h want FFFF", iram_addr); end
        pc_inc = 1'b1; cyc(); pc_inc = 1'b0;
        checks++; if (iram_addr !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", iram_addr); end
        load_imm(c_idx_k, 16'h0010);
        pc_inc = 1'b1; bus_rd = sel(c_idx_k); reg_wr = sel(c_idx_pc); cyc();
        pc_inc = 1'b0; reg_wr = '0; bus_rd = sel(c_idx_ac);
        checks++; if (iram_addr !== 16'h0010) begin errors++; $display("FAIL pc_load_priority got %h want 0010", iram_addr); end
        pc_inc = 1'b1; cyc(); pc_inc = 1'b0;
        checks++; if (iram_addr !== 16'h0011) begin errors++; $display("FAIL pc_inc got %h want 0011", iram_addr); end
    endtask

    task automatic test_mem_read();
        logic [15:0] v;
        int pulses;
        load_imm(c_idx_mar, 16'h0040);
        dram_read = 1'b1; cyc(); dram_read = 1'b0;
        checks++; if ({dram_bus.dram_req, dram_bus.dram_we, mem_busy} !== 3'b101 || dram_bus.dram_addr !== 16'h0040) begin errors++; $display("FAIL rd_req got req=%b we=%b busy=%b addr=%h want 1 0 1 0040", dram_bus.dram_req, dram_bus.dram_we, mem_busy, dram_bus.dram_addr); end
        cyc();
        checks++; if ({dram_bus.dram_req, mem_busy} !== 2'b01) begin errors++; $display("FAIL rd_wait got req=%b busy=%b want 0 1", dram_bus.dram_req, mem_busy); end
        cyc();
        dram_bus.dram_rdata = 16'hBEEF; dram_bus.dram_ack = 1'b1; cyc(); dram_bus.dram_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_done === 1'b1) pulses++;
            cyc();
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rd_done_pulses got %0d want 1", pulses); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after got %b want 0", mem_busy); end
        peek(c_idx_mdr, v);
        checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL rd_mdr got %h want BEEF", v); end

        load_imm(c_idx_k, 16'h1111);
        dram_read = 1'b1; cyc(); dram_read = 1'b0; cyc();
        dram_bus.dram_rdata = 16'h2222; dram_bus.dram_ack = 1'b1;
        bus_rd = sel(c_idx_k); reg_wr = sel(c_idx_mdr); cyc();
        dram_bus.dram_ack = 1'b0; reg_wr = '0; bus_rd = sel(c_idx_ac);
        cyc(); cyc();
        peek(c_idx_mdr, v);
        checks++; if (v !== 16'h2222) begin errors++; $display("FAIL rd_vs_load_mdr got %h want 2222", v); end

        dram_bus.dram_ack = 1'b1; cyc(); cyc(); dram_bus.dram_ack = 1'b0;
        checks++; if ({mem_busy, mem_done, dram_bus.dram_req} !== 3'b000) begin errors++; $display("FAIL idle_ack got busy=%b done=%b req=%b want 0 0 0", mem_busy, mem_done, dram_bus.dram_req); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rd_bus_err got %b want 0", bus_err); end
    endtask

    task automatic test_mem_write();
        logic [15:0] v;
        load_imm(c_idx_mdr, 16'h1357);
        load_imm(c_idx_mar, 16'h0090);
        dram_write = 1'b1; cyc(); dram_write = 1'b0;
        checks++; if ({dram_bus.dram_req, dram_bus.dram_we} !== 2'b11 || dram_bus.dram_addr !== 16'h0090 || dram_bus.dram_wdata !== 16'h1357) begin errors++; $display("FAIL wr_req got req=%b we=%b addr=%h wdata=%h want 1 1 0090 1357", dram_bus.dram_req, dram_bus.dram_we, dram_bus.dram_addr, dram_bus.dram_wdata); end
        cyc();
        dram_bus.dram_rdata = 16'hFFFF; dram_bus.dram_ack = 1'b1; cyc(); dram_bus.dram_ack = 1'b0;
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL wr_done got %b want 1", mem_done); end
        cyc();
        peek(c_idx_mdr, v);
        checks++; if (v !== 16'h1357) begin errors++; $display("FAIL wr_mdr_kept got %h want 1357", v); end
    endtask

    task automatic test_busy_reject();
        logic [15:0] v;
        load_imm(c_idx_mar, 16'h0080);
        dram_read = 1'b1; cyc(); dram_read = 1'b0; cyc();
        dram_write = 1'b1; cyc(); dram_write = 1'b0;
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL busy_bus_err got %b want 1", bus_err); end
        checks++; if ({mem_busy, dram_bus.dram_req} !== 2'b10 || dram_bus.dram_addr !== 16'h0080) begin errors++; $display("FAIL busy_hold got busy=%b req=%b addr=%h want 1 0 0080", mem_busy, dram_bus.dram_req, dram_bus.dram_addr); end
        dram_bus.dram_rdata = 16'hA5A5; dram_bus.dram_ack = 1'b1; cyc(); dram_bus.dram_ack = 1'b0;
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL busy_orig_done got %b want 1", mem_done); end
        cyc(); cyc();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL busy_no_new_txn got %b want 0", mem_busy); end
        peek(c_idx_mdr, v);
        checks++; if (v !== 16'hA5A5) begin errors++; $display("FAIL busy_orig_mdr got %h want A5A5", v); end
    endtask

    task automatic test_both_pulses();
        do_reset();
        load_imm(c_idx_mdr, 16'h0077);
        load_imm(c_idx_mar, 16'h0020);
        dram_read = 1'b1; dram_write = 1'b1; cyc(); dram_read = 1'b0; dram_write = 1'b0;
        checks++; if (dram_bus.dram_we !== 1'b1 || dram_bus.dram_wdata !== 16'h0077) begin errors++; $display("FAIL both_write got we=%b wdata=%h want 1 0077", dram_bus.dram_we, dram_bus.dram_wdata); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL both_bus_err got %b want 1", bus_err); end
        cyc();
        dram_bus.dram_ack = 1'b1; cyc(); dram_bus.dram_ack = 1'b0; cyc();
    endtask

    task automatic test_bus_fault();
        logic [15:0] v;
        do_reset();
        load_imm(c_idx_l, 16'h00AB);
        bus_rd = '0; reg_wr = sel(c_idx_l); cyc(); reg_wr = '0; bus_rd = sel(c_idx_ac);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL zero_sel_err got %b want 1", bus_err); end
        peek(c_idx_l, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL zero_sel_bus got %h want 0000", v); end
        do_reset();
        load_imm(c_idx_x, 16'h0F00);
        load_imm(c_idx_k, 16'h00F0);
        bus_rd = sel(c_idx_x) | sel(c_idx_k); reg_wr = sel(c_idx_t); cyc(); reg_wr = '0; bus_rd = sel(c_idx_ac);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL multi_sel_err got %b want 1", bus_err); end
        peek(c_idx_t, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL multi_sel_bus got %h want 0000", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int pulses;
        do_reset();
        load_imm(c_idx_mar, 16'h0030);
        dram_read = 1'b1; cyc(); dram_read = 1'b0; cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if ({mem_busy, dram_bus.dram_req} !== 2'b00 || dram_bus.dram_addr !== 16'h0) begin errors++; $display("FAIL midrst_state got busy=%b req=%b addr=%h want 0 0 0000", mem_busy, dram_bus.dram_req, dram_bus.dram_addr); end
        dram_bus.dram_rdata = 16'hDEAD; dram_bus.dram_ack = 1'b1; cyc(); dram_bus.dram_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_done === 1'b1) pulses++;
            cyc();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", pulses); end
        peek(c_idx_mdr, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL midrst_mdr got %h want 0000", v); end
    endtask

    initial begin
        reset = 1'b1; bus_rd = sel(c_idx_ac); reg_wr = '0; alu_op = 3'd0; alu_mux = 1'b0;
        ac_reset = 1'b0; pc_inc = 1'b0; iram_read = 1'b0; dram_read = 1'b0; dram_write = 1'b0;
        iram_data = 24'h0; dram_bus.dram_rdata = 16'h0; dram_bus.dram_ack = 1'b0;
        test_reset();
        test_bus_move();
        test_alu();
        test_pc();
        test_mem_read();
        test_mem_write();
        test_busy_reject();
        test_both_pulses();
        test_bus_fault();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 Parameter DW, default 16, width of data bus and every general register.
REQ-002 Parameter AW, default 16, width of PC, MAR, iram_addr, dram_addr.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bus_rd  input  14  one-hot bus-source select (bit map in package): AC,L,X,CenterP,J,T,H,W,K,Count,MAR,MDR,PC,IR.
REQ-006 reg_wr  input  14  per-register load strobe, same bit map; IR bit ignored.
REQ-007 alu_op  input  3  ALU operation code.
REQ-008 alu_mux  input  1  AC load source: 0 = bus, 1 = ALU result.
REQ-009 ac_reset  input  1  clear AC and neg_flag.
REQ-010 pc_inc  input  1  increment PC.
REQ-011 iram_read  input  1  load IR from iram_data.
REQ-012 dram_read  input  1  one-cycle pulse, start DRAM read at MAR.
REQ-013 dram_write  input  1  one-cycle pulse, start DRAM write of MDR at MAR.
REQ-014 iram_addr  output  AW  instruction address, combinationally equal to PC.
REQ-015 iram_data  input  24  instruction word.
REQ-016 dram_req, dram_we  output  1 each  memory request, write qualifier.
REQ-017 dram_addr, dram_wdata  output  AW, DW  registered address/data of current request.
REQ-018 dram_rdata, dram_ack  input  DW, 1  read data, completion acknowledge.
REQ-019 ir_out  output  24  current IR to controller; neg_flag  output  1  AC sign.
REQ-020 mem_busy, mem_done, bus_err  output  1 each  transaction active, one-cycle completion pulse, sticky bus fault.

Function
REQ-021 bus = selected register (IR contributes IR[DW-1:0]); zero bus_rd or more than one bit set -> bus = 0 and bus_err set.
REQ-022 reg_wr[i] loads bus into register i next edge; several targets may load in one cycle.
REQ-023 AC load when reg_wr[AC]: alu_mux=0 -> bus; alu_mux=1 -> ALU(AC,bus).
REQ-024 ALU ops mod 2^DW: 0 pass bus, 1 AC+bus, 2 AC-bus, 3 AC+1, 4 AC-1, 5 AND, 6 OR, 7 AC<<1.
REQ-025 neg_flag registered = MSB of new AC on every AC load; unchanged otherwise.
REQ-026 ac_reset beats reg_wr[AC]: AC=0, neg_flag=0.
REQ-027 PC: reg_wr[PC] beats pc_inc; pc_inc alone -> PC+1, wraps all-ones to 0.
REQ-028 iram_read: IR <= iram_data next edge.
REQ-029 Memory FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
REQ-030 IDLE + dram_read/dram_write: latch MAR (and MDR for write) into dram_addr/dram_wdata, go REQ; both pulses together -> write taken, bus_err set.
REQ-031 REQ: dram_req=1 one cycle, dram_we per op, then WAIT; dram_req low in WAIT.
REQ-032 WAIT: hold until dram_ack; on ack in read, MDR <= dram_rdata; go DONE. No timeout.
REQ-033 DONE: mem_done=1 one cycle; mem_busy=1 in REQ, WAIT and DONE.
REQ-034 dram_read/dram_write while mem_busy ignored, bus_err set.
REQ-035 Read completion and reg_wr[MDR] same edge: dram_rdata wins.
REQ-036 dram_ack outside WAIT ignored.

Reset
REQ-037 reset: all registers, PC, IR, neg_flag, bus_err = 0; FSM IDLE; dram_req, dram_we, mem_busy, mem_done = 0; dram_addr, dram_wdata = 0.
REQ-038 reset mid-transaction abandons it: no MDR update, no mem_done; late dram_ack ignored.

Structure
REQ-039 Package bus_datapath_pkg holds bus-index constants, ALU opcode constants, memory FSM state enum.
REQ-040 One sub-module dp_alu: combinational ALU, inputs AC, bus, alu_op.

Verification
REQ-041 bus_rd=X, X=0x1234, reg_wr=L -> L=0x1234 next cycle, bus_err=0.
REQ-042 AC=0x0001, bus=0x0002, alu_op=2, alu_mux=1, reg_wr=AC -> AC=0xFFFF, neg_flag=1; then ac_reset -> AC=0, neg_flag=0.
REQ-043 MAR=0x0040, dram_read pulse, ack 3 cycles after dram_req with rdata 0xBEEF -> MDR=0xBEEF, mem_done pulses once, mem_busy low after.
REQ-044 dram_write while WAIT -> ignored, bus_err=1, original transaction completes.
REQ-045 PC=0xFFFF, pc_inc -> PC=0; pc_inc with reg_wr[PC], bus=0x0010 -> PC=0x0010.
REQ-046 reset asserted in WAIT, dram_ack arrives after release -> MDR=0, mem_done stays 0.
